// File: rtl/fetch_queue_if.sv
// Handshake bundle between instruction fetch, the fetch queue and decode.
// master = fetch/decode side that drives requests; slave = the queue itself.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_is_ctrl;
    logic          flush;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_pc, in_instr, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_instr, out_is_ctrl, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready, flush,
        output in_ready, out_valid, out_pc, out_instr, out_is_ctrl, count
    );
endinterface

// File: rtl/fetch_queue.sv
// First-word-fall-through instruction queue between fetch and decode.
// Stores {pc, instr} pairs, presents the oldest one combinationally, flags
// control-flow opcodes at the head and drops everything on a redirect flush.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Branch, JAL and JALR opcodes redirect the pipeline.
    function automatic logic is_ctrl_f(input logic [6:0] opcode);
        logic r;
        case (opcode)
            7'b1100011: r = 1'b1;
            7'b1101111: r = 1'b1;
            7'b1100111: r = 1'b1;
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

    logic [31:0]   mem_pc_q    [DEPTH];
    logic [31:0]   mem_instr_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          in_ready_s;
    logic          out_valid_s;
    logic          push_s;
    logic          pop_s;
    logic [31:0]   head_pc_s;
    logic [31:0]   head_instr_s;
    logic          head_ctrl_s;

    // Full/empty come only from registered count, so a full queue refuses a
    // push even when decode pops in the same cycle.
    assign in_ready_s  = (count_q != CW'(DEPTH));
    assign out_valid_s = (count_q != {CW{1'b0}});
    assign push_s      = bus.in_valid  & in_ready_s  & ~bus.flush;
    assign pop_s       = bus.out_ready & out_valid_s & ~bus.flush;

    // Next-state for pointers and occupancy; flush overrides any handshake.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_pc_q[wr_ptr_q]    <= bus.in_pc;
            mem_instr_q[wr_ptr_q] <= bus.in_instr;
        end
    end

    // Head presentation: oldest entry when occupied, a NOP bubble when empty.
    always_comb begin
        head_pc_s    = 32'h0000_0000;
        head_instr_s = NOP_WORD;
        head_ctrl_s  = 1'b0;
        if (out_valid_s) begin
            head_pc_s    = mem_pc_q[rd_ptr_q];
            head_instr_s = mem_instr_q[rd_ptr_q];
            head_ctrl_s  = is_ctrl_f(mem_instr_q[rd_ptr_q][6:0]);
        end else begin
            head_pc_s    = 32'h0000_0000;
            head_instr_s = NOP_WORD;
            head_ctrl_s  = 1'b0;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_s;
    assign bus.out_pc      = head_pc_s;
    assign bus.out_instr   = head_instr_s;
    assign bus.out_is_ctrl = head_ctrl_s;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized
// run, all compared against a queue-based reference model.
module tb_fetch_queue;
    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    ent_t q[$];
    ent_t popped[$];

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic ref_ctrl(input logic [31:0] instr);
        logic [6:0] op;
        op = instr[6:0];
        return (op == 7'b1100011) || (op == 7'b1101111) || (op == 7'b1100111);
    endfunction

    // Advance one clock and apply the queue rules to the model.
    task automatic tick();
        bit push, pop;
        ent_t e;
        push = bus.in_valid && (q.size() < DEPTH) && !bus.flush;
        pop  = bus.out_ready && (q.size() > 0) && !bus.flush;
        e.pc    = bus.in_pc;
        e.instr = bus.in_instr;
        @(posedge clk);
        if (bus.flush) begin
            q.delete();
        end else begin
            if (pop) popped.push_back(q.pop_front());
            if (push) q.push_back(e);
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        bus.in_pc     = 32'h0;
        bus.in_instr  = 32'h0;
    endtask

    task automatic test_reset();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        n_checks++; if (bus.out_instr !== NOP) begin n_fail++; $display("FAIL reset_instr got=%h exp=%h", bus.out_instr, NOP); end
        n_checks++; if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", bus.out_pc); end
        @(posedge clk); #1; reset = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_pc = 32'h100 + 32'(i * 4); bus.in_instr = 32'h0000_0033; tick();
        end
        bus.in_valid = 1'b0;
        n_checks++; if (bus.count !== CW'(3)) begin n_fail++; $display("FAIL prereset_count got=%0d exp=3", bus.count); end
        #2 reset = 1'b1;
        #1;
        q.delete();
        n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL async_count got=%0d exp=0", bus.count); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got=%b exp=0", bus.out_valid); end
        n_checks++; if (bus.out_instr !== NOP) begin n_fail++; $display("FAIL async_instr got=%h exp=%h", bus.out_instr, NOP); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL async_ready got=%b exp=1", bus.in_ready); end
        @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic test_fill_full();
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_pc = 32'(i * 4); bus.in_instr = 32'h0050_0093 + 32'(i << 20); tick();
        end
        n_checks++; if (bus.count !== CW'(4)) begin n_fail++; $display("FAIL full_count got=%0d exp=4", bus.count); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", bus.in_ready); end
        bus.in_pc = 32'h10; bus.in_instr = 32'h0090_0093; tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.count !== CW'(4)) begin n_fail++; $display("FAIL refused_count got=%0d exp=4", bus.count); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.out_pc !== 32'(i * 4)) begin n_fail++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, bus.out_pc, 32'(i * 4)); end
            n_checks++; if (bus.out_instr !== 32'h0050_0093 + 32'(i << 20)) begin n_fail++; $display("FAIL drain_instr[%0d] got=%h", i, bus.out_instr); end
            tick();
        end
        bus.out_ready = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drained_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_full_pop();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_pc = 32'h200 + 32'(i * 4); bus.in_instr = 32'h0000_0033; tick();
        end
        bus.out_ready = 1'b1; bus.in_pc = 32'h240;
        tick();
        n_checks++; if (bus.count !== CW'(3)) begin n_fail++; $display("FAIL fullpop_count got=%0d exp=3", bus.count); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_ready got=%b exp=1", bus.in_ready); end
        tick();
        n_checks++; if (bus.count !== CW'(3)) begin n_fail++; $display("FAIL pushpop_count got=%0d exp=3", bus.count); end
        n_checks++; if (bus.out_pc !== 32'h208) begin n_fail++; $display("FAIL pushpop_head got=%h exp=208", bus.out_pc); end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (popped[popped.size()-1].pc !== 32'h240) begin n_fail++; $display("FAIL fullpop_last got=%h exp=240", popped[popped.size()-1].pc); end
        n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL fullpop_empty got=%0d exp=0", bus.count); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_pc = 32'(i * 4); bus.in_instr = 32'h0010_0093; tick();
            n_checks++; if (bus.out_valid !== 1'b1 || bus.count !== CW'(1)) begin n_fail++; $display("FAIL b2b_state[%0d] valid=%b count=%0d exp 1/1", i, bus.out_valid, bus.count); end
            n_checks++; if (bus.out_pc !== 32'(i * 4)) begin n_fail++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", i, bus.out_pc, 32'(i * 4)); end
        end
        bus.in_valid = 1'b0; tick(); bus.out_ready = 1'b0;
        n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL b2b_end got=%0d exp=0", bus.count); end
    endtask

    task automatic test_flush();
        bus.in_valid = 1'b1;
        bus.in_pc = 32'h300; tick();
        bus.in_pc = 32'h304; tick();
        bus.flush = 1'b1; bus.out_ready = 1'b1; bus.in_pc = 32'h99C; popped.delete();
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        n_checks++; if (bus.count !== CW'(0) || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty count=%0d valid=%b exp 0/0", bus.count, bus.out_valid); end
        tick(); tick();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL flush_stays valid=%b pc=%h exp 0/0", bus.out_valid, bus.out_pc); end
        n_checks++; if (popped.size() !== 0) begin n_fail++; $display("FAIL flush_popped got=%0d exp=0", popped.size()); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_ctrl();
        logic [31:0] words [4];
        logic        exp   [4];
        words = '{32'h0000_006F, 32'h0020_8463, 32'h0000_8067, 32'h0000_0033};
        exp   = '{1'b1, 1'b1, 1'b1, 1'b0};
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_pc = 32'h400 + 32'(i * 4); bus.in_instr = words[i]; tick();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.out_is_ctrl !== exp[i] || bus.out_instr !== words[i]) begin n_fail++; $display("FAIL ctrl[%0d] ctrl=%b instr=%h exp %b/%h", i, bus.out_is_ctrl, bus.out_instr, exp[i], words[i]); end
            tick();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [6:0]  ops [4];
        logic [31:0] w;
        ops = '{7'b1100011, 7'b1101111, 7'b1100111, 7'b0010011};
        for (int i = 0; i < 500; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.in_pc     = $urandom;
            w             = $urandom;
            if ($urandom_range(0, 1) == 1) w[6:0] = ops[$urandom_range(0, 3)];
            bus.in_instr  = w;
            n_checks++; if (bus.count !== CW'(q.size())) begin n_fail++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, bus.count, q.size()); end
            n_checks++; if (bus.in_ready !== (q.size() != DEPTH)) begin n_fail++; $display("FAIL rnd_ready[%0d] got=%b", i, bus.in_ready); end
            n_checks++; if (bus.out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d] got=%b", i, bus.out_valid); end
            if (q.size() != 0) begin
                n_checks++; if (bus.out_pc !== q[0].pc || bus.out_instr !== q[0].instr) begin n_fail++; $display("FAIL rnd_head[%0d] got=%h/%h exp=%h/%h", i, bus.out_pc, bus.out_instr, q[0].pc, q[0].instr); end
                n_checks++; if (bus.out_is_ctrl !== ref_ctrl(q[0].instr)) begin n_fail++; $display("FAIL rnd_ctrl[%0d] got=%b", i, bus.out_is_ctrl); end
            end else begin
                n_checks++; if (bus.out_pc !== 32'h0 || bus.out_instr !== NOP || bus.out_is_ctrl !== 1'b0) begin n_fail++; $display("FAIL rnd_empty[%0d] got=%h/%h/%b", i, bus.out_pc, bus.out_instr, bus.out_is_ctrl); end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_fill_full();
        test_full_pop();
        test_back_to_back();
        test_flush();
        test_ctrl();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
